// File: rtl/bias_pkg.sv
// Shared encodings and derived-geometry helpers for the bias packer.
// Mode values track the conv controller's layer modes.
package bias_pkg;

  typedef enum logic [1:0] {
    MODE_CONV  = 2'd0,
    MODE_DW    = 2'd1,
    MODE_PW    = 2'd2,
    MODE_AVGPL = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam int unsigned DEF_IN_W   = 128;
  localparam int unsigned DEF_BIAS_W = 32;
  localparam int unsigned DEF_LANES  = 16;
  localparam int unsigned DEF_CNT_W  = 11;

  // Elements per input beat and beats per packed output word
  function automatic int unsigned epb_of(int unsigned in_w, int unsigned bias_w);
    return in_w / bias_w;
  endfunction

  function automatic int unsigned beats_of(int unsigned in_w, int unsigned bias_w,
                                           int unsigned lanes);
    return (lanes * bias_w) / in_w;
  endfunction

  function automatic int unsigned cnt_w_of(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned EPB   = epb_of(DEF_IN_W, DEF_BIAS_W);
  localparam int unsigned BEATS = beats_of(DEF_IN_W, DEF_BIAS_W, DEF_LANES);

endpackage

// File: rtl/bias_word_asm.sv
// Slot storage for partial beats plus the PACK / BCAST word-assembly mux.
module bias_word_asm
  import bias_pkg::*;
#(
  parameter  int unsigned IN_W    = DEF_IN_W,
  parameter  int unsigned BIAS_W  = DEF_BIAS_W,
  parameter  int unsigned LANES   = DEF_LANES,
  localparam int unsigned OUT_W   = LANES * BIAS_W,
  localparam int unsigned NEPB    = epb_of(IN_W, BIAS_W),
  localparam int unsigned NBEATS  = beats_of(IN_W, BIAS_W, LANES),
  localparam int unsigned BEAT_CW = cnt_w_of(NBEATS)
) (
  input  logic               clk_200M,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               slot_we,
  input  logic [BEAT_CW-1:0] slot_idx,
  input  logic               bcast,
  input  logic [IN_W-1:0]    bias_in,
  output logic [OUT_W-1:0]   word_c
);

  localparam int unsigned NSLOT = (NBEATS > 1) ? NBEATS - 1 : 1;

  logic [IN_W-1:0] slot_q [NSLOT];

  // Beats 0..NBEATS-2 wait here; the final beat bypasses straight into the word
  always_ff @(posedge clk_200M or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < NSLOT; k++) slot_q[k] <= '0;
    end else if (clr) begin
      for (int unsigned k = 0; k < NSLOT; k++) slot_q[k] <= '0;
    end else begin
      for (int unsigned k = 0; k < NSLOT; k++)
        if (slot_we && (slot_idx == BEAT_CW'(k))) slot_q[k] <= bias_in;
    end
  end

  always_comb begin
    word_c = '0;
    if (bcast) begin
      // Element e fans out to lanes e*NBEATS .. e*NBEATS+NBEATS-1
      for (int unsigned e = 0; e < NEPB; e++)
        for (int unsigned r = 0; r < NBEATS; r++)
          word_c[(e*NBEATS + r)*BIAS_W +: BIAS_W] = bias_in[e*BIAS_W +: BIAS_W];
    end else begin
      for (int unsigned k = 0; k + 1 < NBEATS; k++)
        word_c[k*IN_W +: IN_W] = slot_q[k];
      word_c[(NBEATS-1)*IN_W +: IN_W] = bias_in;
    end
  end

endmodule

// File: rtl/bias_pack_ctrl.sv
// Converts narrow bias beats into wide bias-FIFO words per layer descriptor,
// with pack, broadcast and no-bias modes and full FIFO backpressure.
module bias_pack_ctrl
  import bias_pkg::*;
#(
  parameter  int unsigned IN_W   = DEF_IN_W,
  parameter  int unsigned BIAS_W = DEF_BIAS_W,
  parameter  int unsigned LANES  = DEF_LANES,
  parameter  int unsigned CNT_W  = DEF_CNT_W,
  localparam int unsigned OUT_W  = LANES * BIAS_W
) (
  input  logic             clk_200M,
  input  logic             rst_n,
  input  logic             soft_clr,
  input  logic             cfg_vld,
  output logic             cfg_rdy,
  input  logic [1:0]       cfg_mode,
  input  logic [CNT_W-1:0] cfg_words,
  input  logic             bias_in_vld,
  output logic             bias_in_rdy,
  input  logic [IN_W-1:0]  bias_in,
  input  logic             fifo_full,
  output logic             fifo_wr_en,
  output logic [OUT_W-1:0] fifo_wr_data,
  output logic             layer_done,
  output logic             busy
);

  localparam int unsigned NBEATS  = beats_of(IN_W, BIAS_W, LANES);
  localparam int unsigned BEAT_CW = cnt_w_of(NBEATS);

  state_e             state_q, state_d;
  mode_e              mode_q, mode_d;
  logic [CNT_W-1:0]   words_q, words_d;
  logic [CNT_W-1:0]   in_cnt_q, in_cnt_d;
  logic [CNT_W-1:0]   out_cnt_q, out_cnt_d;
  logic [BEAT_CW-1:0] beat_q, beat_d;
  logic               pend_q, pend_d;
  logic [OUT_W-1:0]   data_q, data_d;
  logic               done_q, done_d;

  logic             is_bcast, last_beat, accept, launch, wr;
  logic [OUT_W-1:0] word_c;

  assign is_bcast     = (mode_q == MODE_DW);
  assign last_beat    = is_bcast | (beat_q == BEAT_CW'(NBEATS - 1));
  assign wr           = pend_q & ~fifo_full;
  // Fall-through on write lets a new word load in the cycle the old one leaves
  assign bias_in_rdy  = (state_q == ST_RUN) & (in_cnt_q != words_q) & (~pend_q | wr);
  assign accept       = bias_in_vld & bias_in_rdy;
  assign launch       = accept & last_beat;

  assign cfg_rdy      = (state_q == ST_IDLE);
  assign busy         = (state_q != ST_IDLE);
  assign fifo_wr_en   = wr;
  assign fifo_wr_data = data_q;
  assign layer_done   = done_q;

  bias_word_asm #(
    .IN_W   (IN_W),
    .BIAS_W (BIAS_W),
    .LANES  (LANES)
  ) u_asm (
    .clk_200M (clk_200M),
    .rst_n    (rst_n),
    .clr      (soft_clr),
    .slot_we  (accept & ~last_beat),
    .slot_idx (beat_q),
    .bcast    (is_bcast),
    .bias_in  (bias_in),
    .word_c   (word_c)
  );

  always_ff @(posedge clk_200M or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      mode_q    <= MODE_CONV;
      words_q   <= '0;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      beat_q    <= '0;
      pend_q    <= 1'b0;
      data_q    <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      words_q   <= words_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      beat_q    <= beat_d;
      pend_q    <= pend_d;
      data_q    <= data_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    mode_d    = mode_q;
    words_d   = words_q;
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    beat_d    = beat_q;
    pend_d    = pend_q;
    data_d    = data_q;
    done_d    = 1'b0;

    // A launch wins over a same-cycle write so the new word stays pending
    if (launch) begin
      pend_d   = 1'b1;
      data_d   = word_c;
      in_cnt_d = in_cnt_q + CNT_W'(1);
    end else if (wr) begin
      pend_d = 1'b0;
    end
    if (wr) out_cnt_d = out_cnt_q + CNT_W'(1);
    if (accept && !is_bcast) beat_d = last_beat ? '0 : beat_q + BEAT_CW'(1);

    unique case (state_q)
      ST_IDLE: begin
        if (cfg_vld) begin
          mode_d    = mode_e'(cfg_mode);
          words_d   = cfg_words;
          in_cnt_d  = '0;
          out_cnt_d = '0;
          beat_d    = '0;
          if ((mode_e'(cfg_mode) == MODE_AVGPL) || (cfg_words == '0)) done_d = 1'b1;
          else                                                          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (launch && (in_cnt_d == words_q)) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (wr && (out_cnt_d == words_q)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (soft_clr) begin
      state_d   = ST_IDLE;
      pend_d    = 1'b0;
      beat_d    = '0;
      done_d    = 1'b0;
      in_cnt_d  = '0;
      out_cnt_d = '0;
    end
  end

endmodule

// File: tb/tb_bias_pack_ctrl.sv
// Scoreboard bench for bias_pack_ctrl: expected words queued as beats are
// accepted, popped and compared on every FIFO write.
module tb_bias_pack_ctrl;
  import bias_pkg::*;

  localparam int unsigned IN_W   = 128;
  localparam int unsigned BIAS_W = 32;
  localparam int unsigned LANES  = 16;
  localparam int unsigned CNT_W  = 11;
  localparam int unsigned OUT_W  = LANES * BIAS_W;

  typedef logic [OUT_W-1:0] word_t;

  logic             clk_200M = 1'b0;
  logic             rst_n = 1'b0;
  logic             soft_clr = 1'b0;
  logic             cfg_vld = 1'b0;
  logic             cfg_rdy;
  logic [1:0]       cfg_mode = 2'd0;
  logic [CNT_W-1:0] cfg_words = '0;
  logic             bias_in_vld = 1'b0;
  logic             bias_in_rdy;
  logic [IN_W-1:0]  bias_in = '0;
  logic             fifo_full = 1'b0;
  logic             fifo_wr_en;
  logic [OUT_W-1:0] fifo_wr_data;
  logic             layer_done;
  logic             busy;

  bias_pack_ctrl #(
    .IN_W(IN_W), .BIAS_W(BIAS_W), .LANES(LANES), .CNT_W(CNT_W)
  ) dut (
    .clk_200M(clk_200M), .rst_n(rst_n), .soft_clr(soft_clr),
    .cfg_vld(cfg_vld), .cfg_rdy(cfg_rdy), .cfg_mode(cfg_mode), .cfg_words(cfg_words),
    .bias_in_vld(bias_in_vld), .bias_in_rdy(bias_in_rdy), .bias_in(bias_in),
    .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en), .fifo_wr_data(fifo_wr_data),
    .layer_done(layer_done), .busy(busy)
  );

  always #5 clk_200M = ~clk_200M;

  int unsigned cyc = 0;
  always @(posedge clk_200M) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input word_t got, input word_t exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference model state
  word_t           exp_q[$];
  int unsigned     wr_cyc_q[$];
  int              wr_count = 0;
  bit              mdl_bcast = 1'b0;
  logic [IN_W-1:0] mdl_slot [BEATS];
  int unsigned     mdl_idx = 0;
  int unsigned     last_acc_cyc = 0;
  int unsigned     cfg_cyc = 0;
  int unsigned     done_cyc = 0;

  function automatic word_t bcast_word(input logic [IN_W-1:0] b);
    word_t w = '0;
    for (int e = 0; e < int'(EPB); e++)
      for (int r = 0; r < int'(BEATS); r++)
        w[(e*BEATS + r)*BIAS_W +: BIAS_W] = b[e*BIAS_W +: BIAS_W];
    return w;
  endfunction

  function automatic word_t pack_word(input logic [IN_W-1:0] s0, input logic [IN_W-1:0] s1,
                                      input logic [IN_W-1:0] s2, input logic [IN_W-1:0] s3);
    return {s3, s2, s1, s0};
  endfunction

  always @(negedge clk_200M) begin
    if (rst_n && fifo_wr_en) begin
      wr_count++;
      wr_cyc_q.push_back(cyc);
      check("sb_level", word_t'(exp_q.size() > 0), word_t'(1));
      if (exp_q.size() > 0) check("wr_data", fifo_wr_data, exp_q.pop_front());
    end
  end

  task automatic send_cfg(input mode_e m, input int unsigned w);
    cfg_vld   = 1'b1;
    cfg_mode  = m;
    cfg_words = CNT_W'(w);
    @(negedge clk_200M);
    check("cfg_rdy", word_t'(cfg_rdy), word_t'(1));
    cfg_cyc   = cyc;
    mdl_bcast = (m == MODE_DW);
    mdl_idx   = 0;
    @(posedge clk_200M); #1;
    cfg_vld   = 1'b0;
  endtask

  task automatic drive_beat(input logic [IN_W-1:0] b);
    bit ok = 1'b0;
    bias_in_vld = 1'b1;
    bias_in     = b;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_200M);
      if (bias_in_rdy) begin
        ok = 1'b1;
        last_acc_cyc = cyc;
        break;
      end
    end
    check("beat_acc", word_t'(ok), word_t'(1));
    if (ok) begin
      if (mdl_bcast) exp_q.push_back(bcast_word(b));
      else begin
        mdl_slot[mdl_idx] = b;
        if (mdl_idx == BEATS - 1) begin
          exp_q.push_back(pack_word(mdl_slot[0], mdl_slot[1], mdl_slot[2], mdl_slot[3]));
          mdl_idx = 0;
        end else mdl_idx++;
      end
    end
    @(posedge clk_200M); #1;
    bias_in_vld = 1'b0;
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk_200M);
      if (layer_done) begin
        seen = 1'b1;
        done_cyc = cyc;
        break;
      end
    end
    check("done_seen", word_t'(seen), word_t'(1));
    @(negedge clk_200M);
    check("done_pulse", word_t'(layer_done), word_t'(0));
    @(posedge clk_200M); #1;
  endtask

  int unsigned acc_a, acc_b, base;
  word_t       snap;

  initial begin
    // Reset values
    repeat (2) @(posedge clk_200M);
    @(negedge clk_200M);
    check("rst_busy",  word_t'(busy), word_t'(0));
    check("rst_cfgrdy", word_t'(cfg_rdy), word_t'(1));
    check("rst_inrdy", word_t'(bias_in_rdy), word_t'(0));
    check("rst_wren",  word_t'(fifo_wr_en), word_t'(0));
    check("rst_data",  fifo_wr_data, word_t'(0));
    check("rst_done",  word_t'(layer_done), word_t'(0));
    @(posedge clk_200M); #1;
    rst_n = 1'b1;
    @(posedge clk_200M); #1;

    // CONV, 2 words, back-to-back beats
    wr_cyc_q.delete();
    base = wr_count;
    send_cfg(MODE_CONV, 2);
    for (int k = 1; k <= 8; k++) begin
      drive_beat(IN_W'(k));
      if (k == 4) acc_a = last_acc_cyc;
      if (k == 8) acc_b = last_acc_cyc;
    end
    wait_done();
    check("conv_nwr", word_t'(wr_count - base), word_t'(2));
    if (wr_cyc_q.size() == 2) begin
      check("conv_lat0", word_t'(wr_cyc_q[0]), word_t'(acc_a + 1));
      check("conv_lat1", word_t'(wr_cyc_q[1]), word_t'(acc_b + 1));
      check("conv_done", word_t'(done_cyc), word_t'(wr_cyc_q[1] + 1));
    end

    // DW broadcast, one word per cycle
    wr_cyc_q.delete();
    base = wr_count;
    send_cfg(MODE_DW, 3);
    for (int j = 0; j < 3; j++)
      drive_beat({32'(4 + 16*j), 32'(3 + 16*j), 32'(2 + 16*j), 32'(1 + 16*j)});
    wait_done();
    check("dw_nwr", word_t'(wr_count - base), word_t'(3));
    if (wr_cyc_q.size() == 3) begin
      check("dw_b2b0", word_t'(wr_cyc_q[1]), word_t'(wr_cyc_q[0] + 1));
      check("dw_b2b1", word_t'(wr_cyc_q[2]), word_t'(wr_cyc_q[1] + 1));
      check("dw_done", word_t'(done_cyc), word_t'(wr_cyc_q[2] + 1));
    end

    // PW with FIFO backpressure after the first word
    base = wr_count;
    send_cfg(MODE_PW, 4);
    fork
      begin
        for (int k = 0; k < 16; k++) drive_beat({IN_W'(32'hA000 + k)} << 8);
      end
      begin
        for (int i = 0; i < 200 && wr_count < int'(base + 1); i++) @(negedge clk_200M);
        @(posedge clk_200M); #1;
        fifo_full = 1'b1;
        for (int i = 0; i < 10; i++) begin
          @(negedge clk_200M);
          if (i == 5) snap = fifo_wr_data;
          if (i > 5) check("pw_hold", fifo_wr_data, snap);
          if (i >= 5) check("pw_rdy0", word_t'(bias_in_rdy), word_t'(0));
        end
        if (exp_q.size() > 0) check("pw_head", fifo_wr_data, exp_q[0]);
        @(posedge clk_200M); #1;
        fifo_full = 1'b0;
      end
    join
    wait_done();
    check("pw_nwr", word_t'(wr_count - base), word_t'(4));

    // No-bias layers: AVGPL and zero-word CONV
    foreach (cfg_words[i]) ;
    for (int t = 0; t < 2; t++) begin
      base = wr_count;
      bias_in_vld = 1'b1;
      bias_in     = IN_W'(32'hDEAD);
      if (t == 0) send_cfg(MODE_AVGPL, 5);
      else        send_cfg(MODE_CONV, 0);
      wait_done();
      check("nb_done", word_t'(done_cyc), word_t'(cfg_cyc + 1));
      for (int i = 0; i < 3; i++) begin
        @(negedge clk_200M);
        check("nb_rdy", word_t'(bias_in_rdy), word_t'(0));
      end
      check("nb_nwr", word_t'(wr_count - base), word_t'(0));
      @(posedge clk_200M); #1;
      bias_in_vld = 1'b0;
    end

    // soft_clr mid-word (with a concurrent cfg_vld), then a fresh CONV layer
    base = wr_count;
    send_cfg(MODE_PW, 4);
    drive_beat(IN_W'(32'h5151));
    drive_beat(IN_W'(32'h5252));
    soft_clr  = 1'b1;
    cfg_vld   = 1'b1;
    cfg_mode  = MODE_DW;
    cfg_words = CNT_W'(9);
    @(posedge clk_200M); #1;
    soft_clr = 1'b0;
    cfg_vld  = 1'b0;
    @(negedge clk_200M);
    check("clr_busy", word_t'(busy), word_t'(0));
    check("clr_wren", word_t'(fifo_wr_en), word_t'(0));
    @(posedge clk_200M); #1;
    send_cfg(MODE_CONV, 1);
    for (int k = 0; k < 4; k++) drive_beat(IN_W'(32'h7000 + k));
    wait_done();
    check("clr_nwr", word_t'(wr_count - base), word_t'(1));

    // cfg_vld during RUN is ignored; next descriptor accepted in IDLE
    base = wr_count;
    send_cfg(MODE_CONV, 1);
    drive_beat(IN_W'(32'h11));
    drive_beat(IN_W'(32'h22));
    cfg_vld   = 1'b1;
    cfg_mode  = MODE_DW;
    cfg_words = CNT_W'(7);
    @(negedge clk_200M);
    check("run_cfgrdy", word_t'(cfg_rdy), word_t'(0));
    @(posedge clk_200M); #1;
    cfg_vld = 1'b0;
    drive_beat(IN_W'(32'h33));
    drive_beat(IN_W'(32'h44));
    wait_done();
    check("run_nwr", word_t'(wr_count - base), word_t'(1));
    send_cfg(MODE_DW, 1);
    drive_beat({32'h8, 32'h7, 32'h6, 32'h5});
    wait_done();
    check("idle_nwr", word_t'(wr_count - base), word_t'(2));
    check("sb_drained", word_t'(exp_q.size()), word_t'(0));

    // Asynchronous reset mid-layer
    send_cfg(MODE_CONV, 2);
    for (int k = 0; k < 5; k++) drive_beat(IN_W'(32'h900 + k));
    rst_n = 1'b0;
    #1;
    check("arst_busy",  word_t'(busy), word_t'(0));
    check("arst_cfgrdy", word_t'(cfg_rdy), word_t'(1));
    check("arst_data",  fifo_wr_data, word_t'(0));
    check("arst_wren",  word_t'(fifo_wr_en), word_t'(0));
    exp_q.delete();
    @(posedge clk_200M); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk_200M);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/bias_pack_ctrl.md
Name: bias_pack_ctrl

Overview:
Parametrised successor of the per-layer bias packer. It converts a stream of narrow bias beats into wide bias-FIFO words for the PE array.
- Layer descriptors arrive on a cfg handshake instead of a hard-wired network table.
- Supports pack mode (CONV/PW), broadcast mode (DW) and no-bias mode (AVGPL).
- Honours input valid/ready and output FIFO backpressure.
- Sits between the bias DMA/reader and the bias FIFO feeding the conv datapath.

Parameters:
IN_W, 128, input beat width in bits
BIAS_W, 32, width of one bias element
LANES, 16, bias elements per output word; OUT_W = LANES*BIAS_W
CNT_W, 11, width of the per-layer output-word counter
Derived: EPB = IN_W/BIAS_W (elements per beat); BEATS = OUT_W/IN_W (beats per packed word). Legal only if both divisions are exact and BEATS >= 1.

Ports:
clk_200M  in  1  single clock; all logic on rising edge
rst_n  in  1  asynchronous, active-low reset
soft_clr  in  1  synchronous abort: return to IDLE, drop pending word and partial beats
cfg_vld  in  1  layer descriptor valid
cfg_rdy  out  1  high only in IDLE
cfg_mode  in  2  0 CONV, 1 DW, 2 PW, 3 AVGPL
cfg_words  in  CNT_W  output words to emit for this layer
bias_in_vld  in  1  bias beat valid
bias_in_rdy  out  1  bias beat accepted when vld&rdy
bias_in  in  IN_W  bias beat; element 0 in LSBs
fifo_full  in  1  bias FIFO full
fifo_wr_en  out  1  FIFO write strobe
fifo_wr_data  out  OUT_W  FIFO write word; lane 0 in LSBs
layer_done  out  1  one-cycle pulse when a layer completes
busy  out  1  state != IDLE

Behaviour:
Reset state:
- State IDLE; all counters, slots and flags cleared.
- Outputs: fifo_wr_en=0, fifo_wr_data=0, layer_done=0, busy=0, bias_in_rdy=0, cfg_rdy=1.

States:
- IDLE: cfg_rdy=1. On cfg_vld, latch mode and words.
  - If mode is AVGPL or cfg_words==0: pulse layer_done next cycle and stay in IDLE.
  - Otherwise go to RUN.
- RUN: accept beats and emit words.
  - When the last input beat of the layer has been accepted, go to DRAIN.
- DRAIN: bias_in_rdy=0 and wait for the pending word to be written.
  - On the write of word number cfg_words, pulse layer_done next cycle and return to IDLE.

Pending word:
- A registered flag `pend` marks a word held in fifo_wr_data.
- fifo_wr_en = pend & !fifo_full, driven combinationally from registers plus fifo_full.
- pend clears on write unless a new word is loaded in the same cycle.
- fifo_wr_data holds its value while pend=1, and keeps its last value after the write; it does not return to 0.

Input acceptance:
- bias_in_rdy = (state==RUN) & in_cnt_not_done & (!pend | fifo_wr_en).
- This fall-through path allows one word per cycle in DW mode.

PACK mode (CONV, PW):
- Beat counter counts 0..BEATS-1; beat k is stored in slot k.
- On the accepted beat with counter==BEATS-1, load {bias_in, slot[BEATS-2], …, slot[0]} and set pend.
- Latency: last beat accepted in cycle t, fifo_wr_en in cycle t+1 if !fifo_full.

BCAST mode (DW):
- Every accepted beat produces one word.
- Element e of the beat is replicated into lanes e*BEATS … e*BEATS+BEATS-1.

Counters and completion:
- An input-word counter counts words launched; RUN→DRAIN occurs when it reaches cfg_words.
- An output-word counter counts FIFO writes. Both are CNT_W wide and never wrap within a layer.
- If the layer's final write happens in the same cycle the last word is launched, the launch has priority and DRAIN still waits for that word.

Boundary cases:
- cfg_vld while busy: ignored (cfg_rdy=0).
- fifo_full held indefinitely: word held and no beats lost; bias_in_rdy=0 once pend is set and no write occurs.
- soft_clr in any state: next cycle state=IDLE, pend=0, beat counter=0, layer_done=0. A concurrent cfg_vld is ignored.
- rst_n asserted mid-layer: immediate return to reset values.

Decomposition:
- Shared package bias_pkg holds:
  - mode encodings (CONV/DW/PW/AVGPL, matching the conv controller's mode values);
  - state enum IDLE/RUN/DRAIN;
  - derived-width helper constants EPB and BEATS.
- One sub-module, bias_word_asm: holds the slot registers and the PACK/BCAST word-assembly mux. It is purely datapath apart from the slot registers.

Test Plan:
1. CONV, words=2, beats 0x…01–0x…08 back-to-back, fifo_full=0 → 2 writes, word0={b3,b2,b1,b0}, one cycle after b3 and b7; layer_done 1 cycle after the second write.
2. DW, words=3, beat elements {4,3,2,1} → word lanes 0-3 = 1, lanes 4-7 = 2, lanes 8-11 = 3, lanes 12-15 = 4; 3 consecutive writes, 1 per cycle.
3. PW, words=4, fifo_full high for 10 cycles after the first word → fifo_wr_data stable, bias_in_rdy=0 while pend is held, no beat lost; 4 writes total, correct order.
4. AVGPL with words=5, and CONV with words=0 → no writes, bias_in_rdy never high, layer_done 1 cycle after the cfg handshake.
5. soft_clr after 2 of 4 PW beats, then a new CONV layer → no stale slot data in the new words; first word equals the new beats only.
6. cfg_vld pulsed during RUN → ignored; after layer_done, the next descriptor is accepted in IDLE with cfg_rdy=1.
